// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: memory-interface types shared by the load unit and its reorder buffer,
// plus the load FSM state encoding.
package mem_load_unit_pkg;
    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;
    typedef enum logic [1:0] {MEM_NONE = 2'h0, MEM_LOAD = 2'h1, MEM_STORE = 2'h2} MEM_COMMAND;
    typedef enum logic [1:0] {IDLE = 2'h0, ISSUE = 2'h1, DRAIN = 2'h2} LOAD_STATE;
endpackage

// File: rtl/mem_load_unit_rob.sv
// load_rob: circular reorder buffer of outstanding loads; responses fill slots by tag CAM,
// and lines leave strictly in allocation order from the head.
module load_rob
    import mem_load_unit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  MEM_TAG   push_tag_i,
    input  MEM_TAG   fill_tag_i,
    input  MEM_BLOCK fill_data_i,
    input  logic     pop_i,
    output logic     head_filled_o,
    output MEM_BLOCK head_data_o,
    output logic     full_o,
    output logic     stray_o
);
    localparam int PW = $clog2(DEPTH);
    logic [DEPTH-1:0] valid_q, filled_q, hit;
    MEM_TAG           tag_q  [DEPTH];
    MEM_BLOCK         data_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [PW:0]      count_q;

    // Only slots still waiting for data may match, so a repeated tag counts as stray.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            hit[i] = valid_q[i] && !filled_q[i] && fill_tag_i != '0 && tag_q[i] == fill_tag_i;
    end

    assign stray_o       = fill_tag_i != '0 && hit == '0;
    assign full_o        = count_q == (PW+1)'(DEPTH);
    assign head_filled_o = valid_q[head_q] && filled_q[head_q];
    assign head_data_o   = data_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) begin
                    filled_q[i] <= 1'b1;
                    data_q[i]   <= fill_data_i;
                end
            end
            if (push_i) begin
                valid_q[tail_q]  <= 1'b1;
                filled_q[tail_q] <= 1'b0;
                tag_q[tail_q]    <= push_tag_i;
                tail_q           <= tail_q + 1'b1;
            end
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: fetches a burst of consecutive 64-bit lines through the tagged memory
// port and streams them back in address order, tolerating rejects and out-of-order fills.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int LEN_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  ADDR              req_base_addr,
    input  logic [LEN_W-1:0] req_num_lines,
    output MEM_COMMAND       proc2mem_command,
    output ADDR              proc2mem_addr,
    input  MEM_TAG           mem2proc_transaction_tag,
    input  MEM_BLOCK         mem2proc_data,
    input  MEM_TAG           mem2proc_data_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output MEM_BLOCK         out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);
    LOAD_STATE        state_q, state_d;
    ADDR              base_q;
    logic [LEN_W-1:0] cnt_q, issue_q, out_idx_q;
    logic             err_q, rob_full, head_filled, stray, issue_en, accept, pop;
    MEM_BLOCK         head_data;

    load_rob #(.DEPTH(ROB_DEPTH)) u_rob (
        .clk           (clk),
        .rst           (rst),
        .push_i        (accept),
        .push_tag_i    (mem2proc_transaction_tag),
        .fill_tag_i    (mem2proc_data_tag),
        .fill_data_i   (mem2proc_data),
        .pop_i         (pop),
        .head_filled_o (head_filled),
        .head_data_o   (head_data),
        .full_o        (rob_full),
        .stray_o       (stray)
    );

    // A rejected request (tag 0) leaves issue_q unchanged, so the same address is re-driven.
    assign issue_en         = state_q == ISSUE && !rob_full && !rst;
    assign accept           = issue_en && mem2proc_transaction_tag != '0;
    assign proc2mem_command = issue_en ? MEM_LOAD : MEM_NONE;
    assign proc2mem_addr    = issue_en ? base_q + (ADDR'(issue_q) << 3) : '0;
    assign out_valid        = head_filled;
    assign out_data         = out_valid ? head_data : '0;
    assign out_last         = out_valid && out_idx_q == cnt_q - 1'b1;
    assign pop              = out_valid && out_ready;
    assign req_ready        = state_q == IDLE;
    assign busy             = state_q != IDLE;
    assign err              = err_q;

    assign state_d = state_q == IDLE && req_valid                      ? ISSUE
                   : state_q == ISSUE && accept && issue_q == cnt_q - 1'b1 ? DRAIN
                   : state_q == DRAIN && pop && out_last               ? IDLE
                   : state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            issue_q   <= '0;
            out_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                base_q    <= req_base_addr;
                cnt_q     <= req_num_lines == '0 ? LEN_W'(1) : req_num_lines;
                issue_q   <= '0;
                out_idx_q <= '0;
            end
            if (accept)
                issue_q <= issue_q + 1'b1;
            if (pop)
                out_idx_q <= out_idx_q + 1'b1;
            if (stray)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed bursts against a behavioural tagged memory; issued addresses,
// returned lines and out_last are compared with values derived from each burst's base.
module tb_mem_load_unit;
    import mem_load_unit_pkg::*;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    ADDR        req_base_addr = '0;
    logic [9:0] req_num_lines = '0;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_TAG     mem2proc_transaction_tag = '0, mem2proc_data_tag = '0;
    MEM_BLOCK   mem2proc_data = '0;
    logic       out_valid, out_ready = 1'b1, out_last, busy, err;
    MEM_BLOCK   out_data;

    int     checks = 0, errors = 0;
    int     mode = 0, rej_left = 0, acc = 0, beat = 0, exp_n = 0;
    int     max_out = 0, extra = 0, rejects = 0, early = 0;
    logic   prev_rej = 1'b0, released = 1'b0;
    ADDR    exp_base = '0, rej_addr = '0;
    MEM_TAG next_tag = 4'd1, stray = '0;
    MEM_TAG q_tag[$];
    ADDR    q_addr[$];
    int     q_age[$];

    mem_load_unit #(.ROB_DEPTH(8), .LEN_W(10)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_base_addr            (req_base_addr),
        .req_num_lines            (req_num_lines),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_data                 (out_data),
        .out_last                 (out_last),
        .busy                     (busy),
        .err                      (err)
    );

    always #5 clk = ~clk;

    function automatic MEM_BLOCK line_data(input ADDR a);
        return {a ^ 32'hA5A5_0000, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Memory model: responds on the falling edge so the DUT sees stable values at the next rise.
    always @(negedge clk) begin
        int outst;
        mem2proc_transaction_tag = '0;
        mem2proc_data_tag        = stray;
        mem2proc_data            = '0;
        stray                    = '0;
        if (rst) begin
            q_tag.delete();
            q_addr.delete();
            q_age.delete();
            prev_rej = 1'b0;
        end else begin
            outst = acc - beat;
            if (outst > max_out) max_out = outst;
            if (outst == 8) check("full_no_issue", 64'(proc2mem_command), 64'(MEM_NONE));
            if (mode == 1 && q_tag.size() > 0 && out_valid) early++;
            foreach (q_age[i]) q_age[i]++;
            if (mode == 1 && q_tag.size() == exp_n) released = 1'b1;
            if (mode == 0 && q_tag.size() > 0 && q_age[0] > 2) begin
                mem2proc_data_tag = q_tag.pop_front();
                mem2proc_data     = line_data(q_addr.pop_front());
                void'(q_age.pop_front());
            end else if (mode == 1 && released && q_tag.size() > 0) begin
                mem2proc_data_tag = q_tag.pop_back();
                mem2proc_data     = line_data(q_addr.pop_back());
                void'(q_age.pop_back());
            end
            if (proc2mem_command == MEM_LOAD) begin
                if (prev_rej) check("redrive_addr", proc2mem_addr, rej_addr);
                if (acc >= exp_n) extra++;
                if (rej_left > 0 && proc2mem_addr == rej_addr) begin
                    rej_left--;
                    rejects++;
                    prev_rej = 1'b1;
                end else begin
                    prev_rej = 1'b0;
                    check("issue_addr", proc2mem_addr, exp_base + 32'(acc) * 8);
                    mem2proc_transaction_tag = next_tag;
                    q_tag.push_back(next_tag);
                    q_addr.push_back(proc2mem_addr);
                    q_age.push_back(0);
                    next_tag = next_tag == 4'd15 ? 4'd1 : next_tag + 4'd1;
                    acc++;
                end
            end else if (prev_rej) begin
                check("redrive_cmd", 64'(proc2mem_command), 64'(MEM_LOAD));
                prev_rej = 1'b0;
            end
            if (out_valid) begin
                check("beat_data", out_data, line_data(exp_base + 32'(beat) * 8));
                check("beat_last", 64'(out_last), 64'(beat == exp_n - 1));
                if (out_ready) beat++;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cmd"}, 64'(proc2mem_command), 64'(MEM_NONE));
        check({tag, "_addr"}, 64'(proc2mem_addr), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
    endtask

    task automatic start_burst(input ADDR b, input logic [9:0] n, input int m);
        exp_base = b;
        exp_n    = n == 0 ? 1 : int'(n);
        mode     = m;
        acc      = 0;
        beat     = 0;
        max_out  = 0;
        extra    = 0;
        rejects  = 0;
        early    = 0;
        released = 1'b0;
        req_valid     = 1'b1;
        req_base_addr = b;
        req_num_lines = n;
        wait_cycles(1);
        req_valid = 1'b0;
    endtask

    task automatic finish_burst(input string tag);
        int c = 0;
        while (!(beat == exp_n && req_ready) && c < 20000) begin
            wait_cycles(1);
            c++;
        end
        check({tag, "_beats"}, 64'(beat), 64'(exp_n));
        check({tag, "_accepts"}, 64'(acc), 64'(exp_n));
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_extra_loads"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int c;
        wait_cycles(3);
        check_idle("reset");
        check("reset_err", 64'(err), 64'd0);
        rst = 1'b0;
        wait_cycles(1);

        start_burst(32'h1000, 10'd4, 0);
        wait_cycles(1);
        req_valid     = 1'b1;
        req_base_addr = 32'hDEAD_0000;
        req_num_lines = 10'd5;
        wait_cycles(1);
        req_valid = 1'b0;
        finish_burst("basic");
        wait_cycles(3);
        check("busy_req_ignored", 64'(busy), 64'd0);

        start_burst(32'h8000, 10'd512, 0);
        finish_burst("long");
        check("long_max_out_le8", 64'(max_out <= 8), 64'd1);

        rej_addr = 32'h2008;
        rej_left = 3;
        start_burst(32'h2000, 10'd4, 0);
        finish_burst("reject");
        check("reject_count", 64'(rejects), 64'd3);

        start_burst(32'h6000, 10'd8, 1);
        finish_burst("reverse");
        check("reverse_early_valid", 64'(early), 64'd0);

        out_ready = 1'b0;
        start_burst(32'h3000, 10'd16, 0);
        wait_cycles(20);
        check("stall_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
        check("stall_outstanding", 64'(acc - beat), 64'd8);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_beats", 64'(beat), 64'd0);
        out_ready = 1'b1;
        finish_burst("stall");
        check("stall_max_out", 64'(max_out), 64'd8);

        start_burst(32'h5000, 10'd0, 0);
        finish_burst("zero_len");
        check("err_clean", 64'(err), 64'd0);

        start_burst(32'h4000, 10'd16, 0);
        c = 0;
        while (beat < 3 && c < 1000) begin
            wait_cycles(1);
            c++;
        end
        check("midreset_reached_line3", 64'(beat >= 3), 64'd1);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check_idle("midreset");
        check("midreset_err", 64'(err), 64'd0);
        stray = 4'd5;
        wait_cycles(2);
        check("stray_err", 64'(err), 64'd1);
        check("stray_out_valid", 64'(out_valid), 64'd0);
        start_burst(32'h7000, 10'd2, 0);
        finish_burst("post_reset");
        check("err_sticky", 64'(err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 8, the maximum number of outstanding loads (power of 2, 2..15).
REQ-002 SHALL have parameter LEN_W, default 10, the width of the line-count field (max 512 lines).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, burst request valid.
REQ-006 SHALL have port req_ready, output, 1, unit idle and able to accept a request.
REQ-007 SHALL have port req_base_addr, input, ADDR (32), byte address of the first 64-bit line.
REQ-008 SHALL have port req_num_lines, input, LEN_W, number of lines to fetch (0 is treated as 1).
REQ-009 SHALL have ports proc2mem_command (output, MEM_COMMAND) and proc2mem_addr (output, ADDR), the memory request.
REQ-010 SHALL have ports mem2proc_transaction_tag (input, MEM_TAG 4), mem2proc_data (input, MEM_BLOCK 64) and mem2proc_data_tag (input, MEM_TAG 4), the memory responses.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, MEM_BLOCK) and out_last (output, 1), forming the in-order line stream to the compute core.
REQ-012 SHALL have ports busy (output, 1), burst in progress, and err (output, 1), sticky unknown-tag flag.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on req_valid&&req_ready, latching base and count; ISSUE->DRAIN when every line has been accepted; DRAIN->IDLE on the out_valid&&out_ready beat with out_last=1.
REQ-014 SHALL drive req_ready=1 only in IDLE and busy=1 in ISSUE and DRAIN.
REQ-015 In ISSUE with outstanding<ROB_DEPTH, SHALL drive MEM_LOAD with proc2mem_addr=base+8*issue_idx (modulo 2^32); otherwise SHALL drive MEM_NONE with addr 0.
REQ-016 SHALL count a load accepted when mem2proc_transaction_tag!=0 in the same cycle as MEM_LOAD; it SHALL then record that tag in the next ROB slot and increment issue_idx.
REQ-017 A tag of 0 SHALL mean rejected; the same address SHALL be re-driven on the next cycle with no lost or duplicated line.
REQ-018 SHALL match a response when mem2proc_data_tag!=0 and it equals a valid pending slot tag; the data SHALL be written into that slot and the slot marked filled, with responses accepted in any order.
REQ-019 A nonzero data_tag matching no pending slot SHALL be dropped and SHALL set err until reset.
REQ-020 SHALL assert out_valid when the head slot is filled, with out_data taken from the head slot (registered).
REQ-021 SHALL set out_last=1 on line index count-1.
REQ-022 On out_valid&&out_ready the head slot SHALL be freed and the head pointer advanced modulo ROB_DEPTH.
REQ-023 SHALL allow issue-accept, response fill and output pop in the same cycle; a slot freed by a pop is reusable the next cycle.
REQ-024 When the ROB is full (outstanding==ROB_DEPTH) SHALL issue no request; when the ROB is empty, out_valid SHALL be 0.
REQ-025 Latency: a response filling the head slot in cycle N SHALL produce out_valid in cycle N+1.
REQ-026 req_valid while busy SHALL be ignored and not queued.

Reset
REQ-027 On rst SHALL set: state IDLE; all slots invalid; pointers and counters 0; proc2mem_command MEM_NONE; proc2mem_addr 0; out_valid 0; out_data 0; out_last 0; busy 0; err 0; req_ready 1 after rst deasserts.
REQ-028 Reset mid-burst SHALL abandon the burst, and responses to pre-reset tags SHALL be dropped (counted per REQ-019).

Structure
REQ-029 MEM_COMMAND, MEM_TAG, MEM_BLOCK and ADDR SHALL come from sys_defs.svh; the LOAD_STATE enum (IDLE/ISSUE/DRAIN) SHALL be added there.
REQ-030 SHALL contain one sub-module, load_rob, holding slot tag/valid/filled/data arrays, tag CAM match, and head/tail pointers; the FSM and issue logic SHALL stay in mem_load_unit.

Verification
REQ-031 Burst of base 0x1000, 4 lines, memory accepting every cycle, out_ready=1 -> addresses 0x1000/0x1008/0x1010/0x1018 issued once each; 4 beats in order; out_last on beat 4; req_ready=1 after.
REQ-032 Burst of 512 lines at 0x8000, ROB_DEPTH=8 -> never more than 8 outstanding; all 512 lines in address order; no MEM_LOAD after the 512th accept.
REQ-033 Tag 0 returned on 3 consecutive cycles for 0x2008 -> 0x2008 re-driven each cycle, loaded exactly once, output order preserved.
REQ-034 Responses returned in reverse tag order for an 8-line burst -> no out_valid until line 0 is filled; lines then stream 0..7.
REQ-035 out_ready held 0 for 20 cycles -> issue stalls at 8 outstanding with command MEM_NONE; resumes when out_ready=1 with no data loss.
REQ-036 rst asserted at line 3 of 16, then stray data_tag=5 -> all outputs at reset values, response dropped, err=1; a new 2-line burst completes correctly.
